// File: rtl/m_pcpi_issue_buffer_if.sv
// rtl/m_pcpi_issue_buffer_if.sv - PCPI core-side and M-unit-side signal bundle
interface m_pcpi_issue_buffer_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        m_valid;
  logic [31:0] m_insn;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_ready;
  logic [31:0] m_rd;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, m_ready, m_rd,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, m_valid, m_insn, m_rs1, m_rs2
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, m_ready, m_rd,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, m_valid, m_insn, m_rs1, m_rs2
  );
endinterface

// File: rtl/m_pcpi_issue_buffer.sv
// rtl/m_pcpi_issue_buffer.sv - PCPI issue buffer in front of the M unit
// Optional last-result cache enabled by defining M_RESULT_CACHE_EN.
module m_pcpi_issue_buffer #(
  parameter logic [6:0]  DEC_OPCODE  = 7'b0110011,
  parameter logic [6:0]  DEC_FUNC7   = 7'b0000001,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  m_pcpi_issue_buffer_if.slave        bus,
  output logic                        err_wdog
);
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HOLD, S_DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [31:0] insn_q, rs1_q, rs2_q, result_q, wdog_cnt;
  logic        accept, wdog_fire, cache_hit;
  logic [31:0] cache_res;

  assign accept = (state == S_IDLE) && bus.pcpi_valid &&
                  (bus.pcpi_insn[6:0] == DEC_OPCODE) &&
                  (bus.pcpi_insn[31:25] == DEC_FUNC7);

  assign wdog_fire = (WDOG_CYCLES != 0) && (wdog_cnt == WDOG_CYCLES - 1);

`ifdef M_RESULT_CACHE_EN
  logic        c_valid;
  logic [2:0]  c_f3;
  logic [31:0] c_rs1, c_rs2, c_res;

  assign cache_hit = c_valid && (c_f3 == bus.pcpi_insn[14:12]) &&
                     (c_rs1 == bus.pcpi_rs1) && (c_rs2 == bus.pcpi_rs2);
  assign cache_res = c_res;

  // Only genuine M-unit completions refresh the cache; aborts and watchdog zeros never do.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_f3    <= '0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_res   <= '0;
    end else if (state == S_WAIT && bus.m_ready) begin
      c_valid <= 1'b1;
      c_f3    <= insn_q[14:12];
      c_rs1   <= rs1_q;
      c_rs2   <= rs2_q;
      c_res   <= bus.m_rd;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      insn_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      wdog_cnt <= '0;
      err_wdog <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        insn_q   <= bus.pcpi_insn;
        rs1_q    <= bus.pcpi_rs1;
        rs2_q    <= bus.pcpi_rs2;
        wdog_cnt <= '0;
        if (cache_hit) result_q <= cache_res;
      end else if (state == S_WAIT) begin
        wdog_cnt <= wdog_cnt + 32'd1;
      end
      // Completion has priority over both abort and watchdog expiry.
      if (state == S_WAIT) begin
        if (bus.m_ready) begin
          result_q <= bus.m_rd;
        end else if (bus.pcpi_valid && wdog_fire) begin
          result_q <= '0;
          err_wdog <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx       = state;
    bus.m_valid    = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = cache_hit ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        bus.m_valid   = 1'b1;
        bus.pcpi_wait = 1'b1;
        state_nx      = S_WAIT;
      end
      S_WAIT: begin
        bus.pcpi_wait = 1'b1;
        if (bus.m_ready)           state_nx = S_RESP;
        else if (!bus.pcpi_valid)  state_nx = S_DRAIN;
        else if (wdog_fire)        state_nx = S_RESP;
      end
      S_RESP: begin
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = result_q;
        state_nx       = S_HOLD;
      end
      S_HOLD: begin
        state_nx = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.m_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.m_insn = insn_q;
  assign bus.m_rs1  = rs1_q;
  assign bus.m_rs2  = rs2_q;
endmodule
